// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle shift sequencer built on one shared shift stage.
// Each SHIFT cycle applies one power-of-two shift step: 1, 2, 4 or 8 for WIDTH=16.
// The step is chosen from the saved shift amount.
// The four ops are rotate-left, shift-left-logical, shift-right-arithmetic
// and shift-right-logical.
// Optional build macro SHIFT_EARLY_EXIT_EN:
//    defined   - only the set bits of the shift amount get a cycle (minimum one).
//    undefined - the sequence always runs CNT_W cycles.
module shift_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in,
   input  logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] work_reg;
   logic [WIDTH-1:0] work_next;
   logic [WIDTH-1:0] out_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       op_reg;
   logic             busy_reg;
   logic             done_reg;

   // Shift distance for the current step; it is zero when the step is skipped.
   logic [CNT_W-1:0] amt;
   // Asserted on the final SHIFT step of an operation.
   logic             last;
   // Distance the vacated bits come from when rotating.
   logic [31:0]      rot_back;

`ifdef SHIFT_EARLY_EXIT_EN
   // Isolate the lowest remaining set bit of the shift amount.
   // That one-hot value is also the shift distance for this step.
   logic [CNT_W-1:0] low_bit;
   assign low_bit = cnt_reg & (~cnt_reg + 1'b1);
   assign amt     = low_bit;
   assign last    = ((cnt_reg & ~low_bit) == '0);
`else
   localparam int LVL_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
   logic [LVL_W-1:0] level_reg;
   assign amt  = cnt_reg[level_reg] ? (CNT_W'(1) << level_reg) : '0;
   assign last = (level_reg == LVL_W'(CNT_W - 1));
`endif

   assign rot_back = 32'(WIDTH) - 32'(amt);

   // Shared shift stage: shift work_reg by amt, filling vacated bits according to op_reg.
   always_comb begin
      work_next = work_reg;
      case (op_reg)
         2'b00:   work_next = (work_reg << amt) | (work_reg >> rot_back);
         2'b01:   work_next = work_reg << amt;
         2'b10:   work_next = $signed(work_reg) >>> amt;
         default: work_next = work_reg >> amt;
      endcase
   end

   // Sequencer: capture on start, step once per cycle in SHIFT, publish and pulse done at the end.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         work_reg  <= '0;
         out_reg   <= '0;
         cnt_reg   <= '0;
         op_reg    <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
`ifndef SHIFT_EARLY_EXIT_EN
         level_reg <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  work_reg  <= in;
                  cnt_reg   <= cnt;
                  op_reg    <= op;
                  busy_reg  <= 1'b1;
                  state_reg <= SHIFT;
`ifndef SHIFT_EARLY_EXIT_EN
                  level_reg <= '0;
`endif
               end
            end
            SHIFT: begin
               work_reg <= work_next;
`ifdef SHIFT_EARLY_EXIT_EN
               cnt_reg  <= cnt_reg & ~low_bit;
`else
               level_reg <= level_reg + 1'b1;
`endif
               if (last) begin
                  out_reg   <= work_next;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign out  = out_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl.
// Directed cases plus randomized operations are checked against a bit-mapping reference model.
// The model checks both the latency and the result.
// The expected latency follows the SHIFT_EARLY_EXIT_EN macro when it is defined.
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [15:0] in_v;
   logic [3:0]  cnt;
   logic        busy;
   logic        done;
   logic [15:0] out_v;

   int compared = 0;
   int mismatched = 0;

   shift_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .in(in_v), .cnt(cnt),
      .busy(busy), .done(done), .out(out_v)
   );

   always #5 clk = ~clk;

   // Reference result: each destination bit j is taken from its source bit in one full shift by n.
   function automatic logic [15:0] ref_shift(input logic [1:0] o, input logic [15:0] v, input int n);
      logic [15:0] r;
      for (int j = 0; j < 16; j++) begin
         case (o)
            2'b00:   r[j] = v[(j - n + 16) % 16];
            2'b01:   r[j] = (j >= n) ? v[j - n] : 1'b0;
            2'b10:   r[j] = (j + n < 16) ? v[j + n] : v[15];
            default: r[j] = (j + n < 16) ? v[j + n] : 1'b0;
         endcase
      end
      return r;
   endfunction

   function automatic int lat_of(input int n);
`ifdef SHIFT_EARLY_EXIT_EN
      int pc = 0;
      for (int b = 0; b < 4; b++) if ((n >> b) & 1) pc++;
      return (pc == 0) ? 1 : pc;
`else
      return 4;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present an operation at the current negedge and hold start across one rising edge (E0).
   task automatic launch(input logic [1:0] o, input logic [15:0] v, input logic [3:0] n);
      start = 1'b1; op = o; in_v = v; cnt = n;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // From edge count k0 after E0, require busy until done.
   // Then check the latency, the result and that busy is low in the done cycle.
   task automatic wait_done(input int k0, input int lat, input logic [15:0] exp, input string tag);
      int k = k0;
      while (!done && k <= 40) begin
         chk({tag, " busy"}, 32'(busy), 32'd1);
         @(negedge clk);
         k++;
      end
      chk({tag, " latency"}, 32'(k), 32'(lat));
      chk({tag, " out"}, 32'(out_v), 32'(exp));
      chk({tag, " busy@done"}, 32'(busy), 32'd0);
      $display("op=%0d in=%h cnt=%0d -> out=%h latency=%0d", op, in_v, cnt, out_v, k);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [15:0] rv;
      logic [3:0]  rn;
      rst = 1'b1; start = 1'b0; op = '0; in_v = '0; cnt = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset out", 32'(out_v), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases with the expected results written out as constants.
      launch(2'b01, 16'h0001, 4'd4);  wait_done(0, lat_of(4),  16'h0010, "sll1x4");
      @(negedge clk);
      chk("hold done", 32'(done), 32'd0);
      chk("hold out", 32'(out_v), 32'h0010);
      launch(2'b00, 16'h8001, 4'd1);  wait_done(0, lat_of(1),  16'h0003, "rol1");
      launch(2'b00, 16'h1234, 4'd8);  wait_done(0, lat_of(8),  16'h3412, "rol8");
      launch(2'b10, 16'h8000, 4'd15); wait_done(0, lat_of(15), 16'hFFFF, "sra15");
      launch(2'b11, 16'h8000, 4'd15); wait_done(0, lat_of(15), 16'h0001, "srl15");
      launch(2'b10, 16'h4000, 4'd14); wait_done(0, lat_of(14), 16'h0001, "sra14");
      launch(2'b11, 16'hBEEF, 4'd0);  wait_done(0, lat_of(0),  16'hBEEF, "cnt0");
      launch(2'b01, 16'h1111, 4'd5);  wait_done(0, lat_of(5),  16'h2220, "sll5");

      // Back-to-back: the second start is presented in the done cycle.
      launch(2'b11, 16'hF000, 4'd4);  wait_done(0, lat_of(4),  16'h0F00, "b2b");

      // A start pulse while busy is ignored.
      @(negedge clk);
      launch(2'b01, 16'h00FF, 4'd3);
      chk("ign busy0", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b1; in_v = 16'hFFFF;
      @(negedge clk);
      start = 1'b0; in_v = 16'h00FF;
      wait_done(2, lat_of(3), 16'h07F8, "ignore");

      // Reset in the middle of an operation aborts it: no done pulse and out is cleared.
      @(negedge clk);
      launch(2'b01, 16'h0003, 4'd15);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort out", 32'(out_v), 32'd0);
      for (int c = 0; c < 6; c++) begin
         chk("abort done", 32'(done), 32'd0);
         @(negedge clk);
      end

      // When reset and start share an edge, reset wins.
      rst = 1'b1; start = 1'b1; op = 2'b01; in_v = 16'h0001; cnt = 4'd1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst+start busy", 32'(busy), 32'd0);
      for (int c = 0; c < 6; c++) begin
         chk("rst+start done", 32'(done), 32'd0);
         @(negedge clk);
      end

      // Randomized operations, some started back-to-back in the done cycle.
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         rv = 16'($urandom);
         rn = 4'($urandom_range(0, 15));
         launch(ro, rv, rn);
         wait_done(0, lat_of(int'(rn)), ref_shift(ro, rv, int'(rn)), "rand");
         if ($urandom_range(0, 1) == 0) @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle shift sequencer. Accepts a 16-bit operand, a 4-bit shift amount and a 2-bit op.
- Reuses one shared single-level shift stage across cycles, applying the 1/2/4/8 levels serially instead of a full 4-level barrel.
- Sits beside the ALU for area-reduced execute units. Uses a start/busy/done handshake toward the pipeline control.

Parameters:
- WIDTH, 16, operand/result width; must be a power of two.
- CNT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 rotate-left, 01 shift-left-logical, 10 shift-right-arithmetic, 11 shift-right-logical.
- in  input  WIDTH  operand; captured with start.
- cnt  input  CNT_W  shift amount; captured with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when out is updated.
- out  output  WIDTH  result; holds until the next completion.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, out=0. Internal work register, saved cnt, saved op and level counter are all cleared.
- States: IDLE and SHIFT.
  - IDLE: start=1 at an edge (E0) loads work<=in, cnt_r<=cnt, op_r<=op and level<=0, then enters SHIFT.
  - IDLE with start=0: state holds.
- SHIFT, one level per edge:
  - The level-k step shifts work by 2^k when cnt_r[k]=1; otherwise work passes unchanged.
  - Fill rules for each step:
    - op 00: vacated low bits take the top bits (rotate).
    - op 01: vacated low bits are zero.
    - op 10: vacated high bits copy work[WIDTH-1].
    - op 11: vacated high bits are zero.
  - op_r stays constant for the whole operation. The result equals one full shift by cnt (mod WIDTH).
- Fixed mode: SHIFT lasts exactly CNT_W edges (E1..E4 for the default). After E4: out<=final work, done=1 for one cycle, state=IDLE.
- Latency: done is high in the cycle after E4, i.e. 4 cycles after the start edge, independent of cnt.
- busy is 1 after E0 up to and including the cycle ending at E4. It is 0 in the done cycle.
- start while busy=1 is ignored: no queuing, no error.
- Back-to-back: start=1 in the done cycle is accepted (state is IDLE). The next operation begins without a bubble.
- cnt=0 still runs the full sequence; out=in.
- out changes only on completion. Intermediate work values never appear on out.
- rst during SHIFT aborts on that edge: state=IDLE, busy=0, done=0, out=0. No done pulse is produced for the aborted operation.
- rst and start high on the same edge: rst wins and start is dropped.

Optional Feature:
- Macro SHIFT_EARLY_EXIT_EN.
- Defined:
  - Each SHIFT edge applies the lowest remaining set bit of cnt_r, then clears it.
  - SHIFT ends on the edge where the remaining bits become zero.
  - cnt=0 uses one SHIFT edge with no shift.
  - Latency = max(1, popcount(cnt)) cycles. busy/done rules are otherwise unchanged.
- Undefined: fixed CNT_W-cycle latency as above. No early-exit logic is present.

Test Plan:
- op=01, in=0x0001, cnt=4, start one cycle: busy high 4 cycles, then done=1 with out=0x0010. Fixed-mode latency is exactly 4.
- op=00, in=0x8001, cnt=1 gives out=0x0003. op=00, in=0x1234, cnt=8 gives out=0x3412.
- op=10, in=0x8000, cnt=15 gives out=0xFFFF. op=11 with the same operands gives out=0x0001. op=10, in=0x4000, cnt=14 gives out=0x0001.
- Start op=01, in=0x00FF, cnt=3; pulse start again at cycle 2 with in=0xFFFF: the second start is ignored and out=0x07F8. rst at cycle 2 of a new op: busy=0, done never pulses, out=0x0000.
- Back-to-back: second start in the done cycle (op=11, in=0xF000, cnt=4) completes 4 cycles later with out=0x0F00, with no idle cycle between operations.
- With SHIFT_EARLY_EXIT_EN:
  - cnt=0 gives done 1 cycle after start, out=in.
  - cnt=8 gives 1 cycle; cnt=5 gives 2 cycles; cnt=15 gives 4 cycles.
  - Results are identical to fixed mode.
